// File: rtl/genius_round_ctrl.sv
// Round controller for the Genius memory game: plays back the first level+1
// colours from the sequence ROM, then checks player presses against the same
// ROM entries, advancing the level, failing, or declaring a win.
module genius_round_ctrl #(
   parameter int unsigned ON_CYCLES      = 4,
   parameter int unsigned OFF_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] btn,
   input  logic [3:0] rom_data,
   output logic [3:0] address,
   output logic [3:0] led,
   output logic [3:0] level,
   output logic       busy,
   output logic       round_ok,
   output logic       game_over,
   output logic       game_won
);

   // Timer is sized for the largest of the three phase lengths, plus a spare bit.
   localparam int unsigned MaxOnOff  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int unsigned MaxCycles = (MaxOnOff > TIMEOUT_CYCLES) ? MaxOnOff : TIMEOUT_CYCLES;
   localparam int unsigned TimerW    = $clog2(MaxCycles) + 1;

   localparam logic [TimerW-1:0] OnLast      = TimerW'(ON_CYCLES - 1);
   localparam logic [TimerW-1:0] OffLast     = TimerW'(OFF_CYCLES - 1);
   localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]        LastLevel   = 4'd15;

   typedef enum logic [2:0] {
      StIdle,
      StShowOn,
      StShowOff,
      StInput,
      StPause,
      StFail,
      StWin
   } state_e;

   state_e            state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [3:0]        address_q, address_d;
   logic [3:0]        level_q, level_d;

   // State, timer, address and level registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         address_q <= '0;
         level_q   <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         address_q <= address_d;
         level_q   <= level_d;
      end
   end

   // Next-state, timer, address and level decisions.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q + TimerW'(1);
      address_d = address_q;
      level_d   = level_q;

      unique case (state_q)
         StIdle: begin
            timer_d = '0;
            if (start) begin
               level_d   = '0;
               address_d = '0;
               state_d   = StShowOn;
            end
         end

         StShowOn: begin
            if (timer_q == OnLast) begin
               state_d = StShowOff;
            end
         end

         StShowOff: begin
            if (timer_q == OffLast) begin
               if (address_q == level_q) begin
                  address_d = '0;
                  state_d   = StInput;
               end else begin
                  address_d = address_q + 4'd1;
                  state_d   = StShowOn;
               end
            end
         end

         StInput: begin
            // A press on the timeout cycle is evaluated instead of timing out.
            if (btn != 4'b0000) begin
               if (btn == rom_data) begin
                  if (address_q != level_q) begin
                     address_d = address_q + 4'd1;
                     timer_d   = '0;
                  end else if (level_q == LastLevel) begin
                     state_d = StWin;
                  end else begin
                     level_d   = level_q + 4'd1;
                     address_d = '0;
                     state_d   = StPause;
                  end
               end else begin
                  state_d = StFail;
               end
            end else if (timer_q == TimeoutLast) begin
               state_d = StFail;
            end
         end

         StPause: begin
            if (timer_q == OffLast) begin
               state_d = StShowOn;
            end
         end

         StFail, StWin: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Every state entry starts the timer from zero.
      if (state_d != state_q) begin
         timer_d = '0;
      end
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      led       = 4'b0000;
      busy      = 1'b1;
      round_ok  = 1'b0;
      game_over = 1'b0;
      game_won  = 1'b0;
      unique case (state_q)
         StIdle:   busy      = 1'b0;
         StShowOn: led       = rom_data;
         StPause:  round_ok  = (timer_q == '0);
         StFail:   game_over = 1'b1;
         StWin:    game_won  = 1'b1;
         default:  ;
      endcase
   end

   assign address = address_q;
   assign level   = level_q;

endmodule

// File: tb/tb_genius_round_ctrl.sv
// Self-checking bench for genius_round_ctrl: randomized games checked against a
// round-level model of playback, press evaluation, timeout, pause, fail and win.
module tb_genius_round_ctrl;

   localparam int unsigned On  = 4;
   localparam int unsigned Off = 2;
   localparam int unsigned To  = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] btn;
   logic [3:0] rom_data;
   logic [3:0] address;
   logic [3:0] led;
   logic [3:0] level;
   logic       busy;
   logic       round_ok;
   logic       game_over;
   logic       game_won;

   logic [3:0] rom [16];

   int checks = 0;
   int errors = 0;

   genius_round_ctrl #(
      .ON_CYCLES     (On),
      .OFF_CYCLES    (Off),
      .TIMEOUT_CYCLES(To)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .btn      (btn),
      .rom_data (rom_data),
      .address  (address),
      .led      (led),
      .level    (level),
      .busy     (busy),
      .round_ok (round_ok),
      .game_over(game_over),
      .game_won (game_won)
   );

   always #5 clk = ~clk;

   // Combinational colour ROM.
   assign rom_data = rom[address];

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [3:0] rand_onehot();
      logic [3:0] v;
      v = 4'b0001 << $urandom_range(0, 3);
      return v;
   endfunction

   task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      btn   = 4'b0000;
      repeat (3) tick();
      rst = 1'b0;
      check_eq("rst_led", led, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_round_ok", round_ok, 0);
      check_eq("rst_game_over", game_over, 0);
      check_eq("rst_game_won", game_won, 0);
      check_eq("rst_address", address, 0);
      check_eq("rst_level", level, 0);
   endtask

   // Expect (lvl+1) colours, each lit On cycles then dark Off cycles, ending in input phase.
   task automatic playback(input int lvl, input bit noise);
      for (int i = 0; i <= lvl; i++) begin
         for (int c = 0; c < int'(On); c++) begin
            check_eq("pb_led_on", led, rom[i]);
            check_eq("pb_addr", address, i);
            check_eq("pb_level", level, lvl);
            check_eq("pb_busy", busy, 1);
            if (noise) begin
               start = 1'($urandom_range(0, 1));
               btn   = 4'($urandom_range(0, 15));
            end
            tick();
         end
         for (int c = 0; c < int'(Off); c++) begin
            check_eq("pb_led_off", led, 0);
            check_eq("pb_addr_off", address, i);
            check_eq("pb_busy_off", busy, 1);
            if (noise) begin
               start = 1'($urandom_range(0, 1));
               btn   = 4'($urandom_range(0, 15));
            end
            tick();
         end
      end
      start = 1'b0;
      btn   = 4'b0000;
      check_eq("in_led", led, 0);
      check_eq("in_addr", address, 0);
      check_eq("in_busy", busy, 1);
   endtask

   task automatic expect_fail(input int lvl);
      check_eq("fail_pulse", game_over, 1);
      check_eq("fail_busy", busy, 1);
      check_eq("fail_won", game_won, 0);
      check_eq("fail_round_ok", round_ok, 0);
      check_eq("fail_level", level, lvl);
      tick();
      check_eq("fail_idle_busy", busy, 0);
      check_eq("fail_idle_pulse", game_over, 0);
      check_eq("fail_idle_level", level, lvl);
      check_eq("fail_idle_led", led, 0);
   endtask

   // Input phase of one round. err_at<0 means every press correct.
   // kind 0: wrong press (bad_val if non-zero, else random wrong colour),
   // kind 1: random multi-hot press, kind 2: timeout.
   task automatic play_round(input int lvl, input int err_at, input int kind,
                             input logic [3:0] bad_val, input int fixed_idle,
                             output bit ended);
      int         idle;
      logic [3:0] val;
      ended = 1'b0;
      for (int a = 0; a <= lvl; a++) begin
         if (a == err_at && kind == 2) begin
            for (int k = 0; k < int'(To); k++) begin
               check_eq("to_no_early_fail", game_over, 0);
               check_eq("to_addr", address, a);
               tick();
            end
            expect_fail(lvl);
            ended = 1'b1;
            return;
         end
         if (fixed_idle >= 0) idle = fixed_idle;
         else if ($urandom_range(0, 7) == 0) idle = int'(To) - 1;
         else idle = int'($urandom_range(0, 3));
         for (int k = 0; k < idle; k++) begin
            check_eq("wait_led", led, 0);
            check_eq("wait_fail", game_over, 0);
            check_eq("wait_addr", address, a);
            tick();
         end
         if (a == err_at) begin
            if (kind == 1) begin
               do val = 4'($urandom_range(3, 15)); while ($countones(val) < 2);
            end else if (bad_val != 4'b0000) begin
               val = bad_val;
            end else begin
               do val = rand_onehot(); while (val == rom[a]);
            end
         end else begin
            val = rom[a];
         end
         btn = val;
         tick();
         btn = 4'b0000;
         if (a == err_at) begin
            expect_fail(lvl);
            ended = 1'b1;
            return;
         end
         if (a < lvl) begin
            check_eq("step_addr", address, a + 1);
            check_eq("step_busy", busy, 1);
            check_eq("step_round_ok", round_ok, 0);
            check_eq("step_fail", game_over, 0);
         end else if (lvl == 15) begin
            check_eq("win_pulse", game_won, 1);
            check_eq("win_round_ok", round_ok, 0);
            check_eq("win_level", level, 15);
            tick();
            check_eq("win_idle_busy", busy, 0);
            check_eq("win_idle_pulse", game_won, 0);
            check_eq("win_idle_level", level, 15);
            ended = 1'b1;
         end else begin
            for (int c = 0; c < int'(Off); c++) begin
               check_eq("pause_round_ok", round_ok, (c == 0) ? 1 : 0);
               check_eq("pause_led", led, 0);
               check_eq("pause_busy", busy, 1);
               check_eq("pause_level", level, lvl + 1);
               check_eq("pause_addr", address, 0);
               tick();
            end
         end
      end
   endtask

   // Whole game; fail_round<0 plays all 16 rounds to a win.
   task automatic run_game(input int fail_round, input int fail_at, input int kind,
                           input logic [3:0] bad_val, input int fixed_idle, input bit noise);
      bit ended;
      check_eq("game_idle_busy", busy, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int lvl = 0; lvl < 16; lvl++) begin
         playback(lvl, noise);
         play_round(lvl, (lvl == fail_round) ? fail_at : -1, kind, bad_val, fixed_idle, ended);
         if (ended) break;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1);
   end

   initial begin
      bit ended;
      rom[0] = 4'b0001;
      rom[1] = 4'b0100;
      rom[2] = 4'b0010;
      for (int i = 3; i < 16; i++) rom[i] = rand_onehot();
      start = 1'b0;
      btn   = 4'b0000;
      rst   = 1'b1;

      do_reset();

      // Pass round 0, then in round 1 press 0001 then 0010; noise during playback.
      run_game(1, 1, 0, 4'b0010, -1, 1'b1);
      // Multi-hot 0011 at address 0.
      run_game(0, 0, 0, 4'b0011, -1, 1'b0);
      // Timeout in the very first input phase.
      run_game(0, 0, 2, 4'b0000, -1, 1'b0);
      // Every press on the last idle cycle, then a timeout in round 2.
      run_game(2, 1, 2, 4'b0000, int'(To) - 1, 1'b0);

      // Reset in the middle of round-1 playback.
      start = 1'b1;
      tick();
      start = 1'b0;
      playback(0, 1'b0);
      play_round(0, -1, 0, 4'b0000, 0, ended);
      tick();
      check_eq("mid_led_on", led, rom[0]);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mid_rst_led", led, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_level", level, 0);
      check_eq("mid_rst_addr", address, 0);
      tick();
      check_eq("mid_rst_hold", busy, 0);

      // Full win with random gaps and ignored-input noise.
      run_game(-1, -1, 0, 4'b0000, -1, 1'b1);

      // Randomized games with random failure points.
      for (int g = 0; g < 6; g++) begin
         int fr;
         fr = int'($urandom_range(0, 4));
         for (int i = 3; i < 16; i++) rom[i] = rand_onehot();
         run_game(fr, int'($urandom_range(0, fr)), int'($urandom_range(0, 2)), 4'b0000, -1,
                  1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
